// File: rtl/mem_cache.sv
// mem_cache: direct-mapped, write-through, no-write-allocate data cache that
// sits between the core's data-RAM port and the backing data memory.
// Read hits return in the same cycle. Misses and writes stall the core while
// a single req/ack transaction to the backing memory is outstanding.
// Optional build macro MEM_CACHE_STAT_EN adds hit/miss counters
// (hit_cnt_o, miss_cnt_o).
module mem_cache #(
    parameter int INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
`ifdef MEM_CACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int TAG_W = 32 - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q, state_d;

    // Line storage: valid bits are reset, tag/data contents are not
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_ram_q  [LINES];
    logic [31:0]        data_ram_q [LINES];

    // Transaction context captured when a request is issued
    logic [INDEX_W-1:0] idx_q;
    logic [TAG_W-1:0]   tag_q;
    logic               hit_q;
    logic               wr_q;

    // Memory-side request registers and fill return data
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [3:0]         mem_sel_q;
    logic [31:0]        mem_data_q;
    logic [31:0]        rdata_q;

    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    logic               cpu_hit;
    logic               in_idle;
    logic               issue_rd_miss;
    logic               issue_wr;
    logic               rd_hit;
    logic               fill_ack;
    logic               wr_ack;
    logic               unused_addr_bits;

    // Byte-lane merge of new write data into an existing word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    assign cpu_idx          = cpu_addr_i[INDEX_W+1:2];
    assign cpu_tag          = cpu_addr_i[31:INDEX_W+2];
    assign cpu_hit          = valid_q[cpu_idx] && (tag_ram_q[cpu_idx] == cpu_tag);
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    // Decoded request/completion events; nothing is issued or completed while in reset
    assign in_idle       = rst && (state_q == S_IDLE) && cpu_ce_i;
    assign issue_rd_miss = in_idle && !cpu_we_i && !cpu_hit;
    assign issue_wr      = in_idle && cpu_we_i;
    assign rd_hit        = in_idle && !cpu_we_i && cpu_hit;
    assign fill_ack      = rst && (state_q == S_FILL) && mem_ack_i;
    assign wr_ack        = rst && (state_q == S_WRITE) && mem_ack_i;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held request is not reissued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_wr) begin
                    state_d = S_WRITE;
                end else if (issue_rd_miss) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (mem_ack_i) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // CPU-facing outputs: same-cycle hit data, stall while a miss or write is pending
    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
        if (rst) begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_ce_i) begin
                        if (cpu_we_i || !cpu_hit) begin
                            stallreq_o = 1'b1;
                        end else begin
                            cpu_data_o = data_ram_q[cpu_idx];
                        end
                    end
                end
                S_FILL, S_WRITE: begin
                    stallreq_o = 1'b1;
                end
                default: begin
                    cpu_data_o = wr_q ? 32'd0 : rdata_q;
                end
            endcase
        end
    end

    // Memory request registers: set at issue, held until ack, cleared on reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'd0;
            mem_sel_q  <= 4'd0;
            mem_data_q <= 32'd0;
            rdata_q    <= 32'd0;
        end else if (issue_rd_miss) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {cpu_addr_i[31:2], 2'b00};
            mem_sel_q  <= 4'b1111;
        end else if (issue_wr) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_addr_q <= {cpu_addr_i[31:2], 2'b00};
            mem_sel_q  <= cpu_sel_i;
            mem_data_q <= cpu_data_i;
        end else if (fill_ack) begin
            mem_req_q  <= 1'b0;
            rdata_q    <= mem_data_i;
        end else if (wr_ack) begin
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
        end
    end

    // Capture index/tag/hit at issue so completion does not depend on the CPU bus
    always_ff @(posedge clk) begin
        if (issue_rd_miss || issue_wr) begin
            idx_q <= cpu_idx;
            tag_q <= cpu_tag;
            hit_q <= cpu_hit;
            wr_q  <= cpu_we_i;
        end
    end

    // Valid bits: cleared on reset, set when a fill completes
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (fill_ack) begin
            valid_q[idx_q] <= 1'b1;
        end
    end

    // Tag/data arrays: fills overwrite the line, write hits merge, write misses do not allocate
    always_ff @(posedge clk) begin
        if (fill_ack) begin
            data_ram_q[idx_q] <= mem_data_i;
            tag_ram_q[idx_q]  <= tag_q;
        end else if (wr_ack && hit_q) begin
            data_ram_q[idx_q] <= merge_bytes(data_ram_q[idx_q], mem_data_q, mem_sel_q);
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_sel_o  = mem_sel_q;
    assign mem_data_o = mem_data_q;

`ifdef MEM_CACHE_STAT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Read hit/miss statistics; writes are not counted, counters wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (rd_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (issue_rd_miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_rd_hit;
    assign unused_rd_hit = rd_hit;
`endif

endmodule

// File: tb/tb_mem_cache.sv
// Testbench for mem_cache: directed scenarios followed by randomized traffic,
// checked against a line-level cache model and a word-addressed memory model.
module tb_mem_cache;

    logic        clk;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
`ifdef MEM_CACHE_STAT_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    mem_cache #(.INDEX_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_sel_o  (mem_sel_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
`ifdef MEM_CACHE_STAT_EN
        ,
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 64 lines of one word each, plus backing memory by word address
    bit          m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] bmem    [int unsigned];
    int unsigned m_hits  = 0;
    int unsigned m_miss  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        int unsigned key;
        key = {addr[31:2], 2'b00};
        if (!bmem.exists(key)) bmem[key] = $urandom;
        return bmem[key];
    endfunction

    function automatic logic [31:0] apply_sel(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] sel);
        logic [31:0] mask;
        mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        return m_valid[addr[7:2]] && (m_tag[addr[7:2]] == addr[31:8]);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int dly);
        logic [31:0] w;
        bit          hit;
        hit        = model_hit(addr);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = addr;
        cpu_sel_i  = 4'($urandom);
        #1;
        if (hit) begin
            check("rd_hit_stall", {31'd0, stallreq_o}, 32'd0);
            check("rd_hit_data", cpu_data_o, m_data[addr[7:2]]);
            m_hits++;
            tick();
            check("rd_hit_noreq", {31'd0, mem_req_o}, 32'd0);
            cpu_ce_i = 1'b0;
        end else begin
            check("rd_miss_stall", {31'd0, stallreq_o}, 32'd1);
            check("rd_miss_data0", cpu_data_o, 32'd0);
            m_miss++;
            tick();
            check("fill_req", {31'd0, mem_req_o}, 32'd1);
            check("fill_we", {31'd0, mem_we_o}, 32'd0);
            check("fill_addr", mem_addr_o, {addr[31:2], 2'b00});
            check("fill_sel", {28'd0, mem_sel_o}, 32'hF);
            w = mem_word(addr);
            for (int i = 0; i < dly; i++) begin
                tick();
                check("fill_hold_req", {31'd0, mem_req_o}, 32'd1);
                check("fill_hold_stall", {31'd0, stallreq_o}, 32'd1);
            end
            mem_ack_i  = 1'b1;
            mem_data_i = w;
            #1;
            check("fill_ack_stall", {31'd0, stallreq_o}, 32'd1);
            tick();
            mem_ack_i  = 1'b0;
            mem_data_i = $urandom;
            #1;
            check("rd_done_stall", {31'd0, stallreq_o}, 32'd0);
            check("rd_done_data", cpu_data_o, w);
            check("rd_done_req", {31'd0, mem_req_o}, 32'd0);
            m_valid[addr[7:2]] = 1'b1;
            m_tag[addr[7:2]]   = addr[31:8];
            m_data[addr[7:2]]  = w;
            tick();
            cpu_ce_i = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, input int dly);
        bit hit;
        hit        = model_hit(addr);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = data;
        #1;
        check("wr_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        check("wr_req", {31'd0, mem_req_o}, 32'd1);
        check("wr_we", {31'd0, mem_we_o}, 32'd1);
        check("wr_addr", mem_addr_o, {addr[31:2], 2'b00});
        check("wr_sel", {28'd0, mem_sel_o}, {28'd0, sel});
        check("wr_wdata", mem_data_o, data);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("wr_hold_stall", {31'd0, stallreq_o}, 32'd1);
        end
        mem_ack_i = 1'b1;
        #1;
        check("wr_ack_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("wr_done_stall", {31'd0, stallreq_o}, 32'd0);
        check("wr_done_data", cpu_data_o, 32'd0);
        check("wr_done_req", {30'd0, mem_req_o, mem_we_o}, 32'd0);
        bmem[{addr[31:2], 2'b00}] = apply_sel(mem_word(addr), data, sel);
        if (hit) m_data[addr[7:2]] = apply_sel(m_data[addr[7:2]], data, sel);
        tick();
        cpu_ce_i = 1'b0;
        cpu_we_i = 1'b0;
    endtask

    task automatic idle_spurious_ack();
        cpu_ce_i   = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = $urandom;
        #1;
        check("idle_stall", {31'd0, stallreq_o}, 32'd0);
        check("idle_data", cpu_data_o, 32'd0);
        tick();
        mem_ack_i = 1'b0;
        check("idle_noreq", {31'd0, mem_req_o}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          op;
        int unsigned h0, m0;
        rst        = 1'b0;
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h100;
        cpu_sel_i  = 4'hF;
        cpu_data_i = 32'd0;
        mem_data_i = 32'd0;
        mem_ack_i  = 1'b0;
        clear_model();

        // Reset: outputs quiet even with a CPU request present
        tick();
        tick();
        check("rst_stall", {31'd0, stallreq_o}, 32'd0);
        check("rst_cpu_data", cpu_data_o, 32'd0);
        check("rst_req_we", {30'd0, mem_req_o, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_sel", {28'd0, mem_sel_o}, 32'd0);
        check("rst_wdata", mem_data_o, 32'd0);
`ifdef MEM_CACHE_STAT_EN
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
        cpu_ce_i = 1'b0;
        rst      = 1'b1;
        tick();

        // Directed: fill, re-read hit, index conflict, write hit merge, write miss
        bmem[32'h100] = 32'hDEADBEEF;
        bmem[32'h200] = 32'h12345678;
        do_read(32'h100, 3);
        do_read(32'h100, 0);
        check("t1_rehit_data", m_data[0], 32'hDEADBEEF);
        do_read(32'h200, 1);
        do_read(32'h100, 2);
        do_write(32'h100, 32'h000000AA, 4'b0001, 1);
        do_read(32'h100, 0);
        check("t3_merged_mem", bmem[32'h100], 32'hDEADBEAA);
        do_write(32'h300, 32'h55667788, 4'b1111, 0);
        do_read(32'h300, 2);

        // Reset during a fill, followed by a late ack
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h400;
        #1;
        check("t5_issue_stall", {31'd0, stallreq_o}, 32'd1);
        tick();
        check("t5_req", {31'd0, mem_req_o}, 32'd1);
        rst = 1'b0;
        tick();
        check("t5_req_dropped", {31'd0, mem_req_o}, 32'd0);
        check("t5_stall_rst", {31'd0, stallreq_o}, 32'd0);
        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hBAD0BAD0;
        tick();
        mem_ack_i = 1'b0;
        check("t5_late_ack_req", {31'd0, mem_req_o}, 32'd0);
        clear_model();
        do_read(32'h400, 1);
        do_read(32'h300, 0);

        // Statistics: miss, hit, hit, write
`ifdef MEM_CACHE_STAT_EN
        h0 = hit_cnt_o;
        m0 = miss_cnt_o;
`else
        h0 = 0;
        m0 = 0;
`endif
        do_read(32'h0000_1104, 1);
        do_read(32'h0000_1104, 0);
        do_read(32'h0000_1104, 0);
        do_write(32'h0000_1104, 32'h01020304, 4'b0110, 0);
`ifdef MEM_CACHE_STAT_EN
        check("t6_miss_delta", miss_cnt_o - m0, 32'd1);
        check("t6_hit_delta", hit_cnt_o - h0, 32'd2);
`endif

        // Randomized traffic over a few indices with conflicting tags
        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            a  = a | ($urandom_range(0, 1) << 28);
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                do_read(a, $urandom_range(0, 4));
            end else if (op <= 8) begin
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 4));
            end else begin
                idle_spurious_ack();
            end
        end
`ifdef MEM_CACHE_STAT_EN
        check("rand_hit_cnt", hit_cnt_o, m_hits);
        check("rand_miss_cnt", miss_cnt_o, m_miss);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_cache.md
Name: mem_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the CPU core's data-RAM port (ram_ce/we/addr/sel/data) and the backing data memory.
- Answers read hits in the same cycle. Drives the core's stallreq_from_mem_cache input while a miss fill or a write-through is outstanding.
- Backing memory is reached over a req/ack handshake.

Parameters:
INDEX_W, 6, index bits; line count = 2**INDEX_W; one 32-bit word per line
TAG_W, 32-INDEX_W-2, tag width (derived; not overridden)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-low
cpu_ce_i  in  1  CPU data access valid
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  32  byte address; bits [1:0] ignored
cpu_sel_i  in  4  byte enables, bit3 = bits[31:24]
cpu_data_i  in  32  write data
cpu_data_o  out  32  read data to CPU
stallreq_o  out  1  to core stallreq_from_mem_cache
mem_req_o  out  1  backing-memory request
mem_we_o  out  1  backing-memory write
mem_addr_o  out  32  word-aligned address, bits [1:0] = 0
mem_sel_o  out  4  byte enables (4'b1111 on fills)
mem_data_o  out  32  write data to memory
mem_data_i  in  32  read data, valid when mem_ack_i = 1
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split:
  - index = cpu_addr_i[INDEX_W+1:2]
  - tag = cpu_addr_i[31:INDEX_W+2]
  - hit = valid[index] && tag_ram[index] == tag.
- States: IDLE, FILL, WRITE, DONE. Encoded in a 2-bit register.
- IDLE:
  - cpu_ce_i=0: stallreq_o=0, cpu_data_o=0.
  - Read hit: cpu_data_o = data_ram[index] combinationally, stallreq_o=0, state stays IDLE. Zero-cycle latency.
  - Read miss: stallreq_o=1 combinationally. mem_req_o, mem_addr_o and mem_sel_o=4'b1111 are registered, so they appear the next cycle. Next state FILL.
  - Write (hit or miss): stallreq_o=1. Register mem_req_o=1, mem_we_o=1, address, sel and data. Next state WRITE.
- FILL:
  - stallreq_o=1; hold all mem_* outputs stable until mem_ack_i.
  - On ack: write mem_data_i into data_ram[index], the tag into tag_ram, set valid[index]. Latch mem_data_i into rdata_q. Drop mem_req_o. Next state DONE.
- WRITE:
  - stallreq_o=1; hold outputs.
  - On ack: if the line hit at request time, merge cpu_data_i bytes per cpu_sel_i into data_ram[index]. Miss leaves the cache untouched (no allocate). Drop mem_req_o/mem_we_o. Next state DONE.
- DONE:
  - stallreq_o=0; cpu_data_o = rdata_q for reads, 0 for writes.
  - No new request is issued, even though the CPU request is still present this cycle.
  - Next state IDLE unconditionally.
- Memory-side handshake:
  - mem_req_o stays high from the cycle after issue through the ack cycle inclusive.
  - mem_ack_i outside FILL/WRITE is ignored.
  - No outstanding-request limit beyond one.
- CPU-side rule: CPU holds ce/we/addr/sel/data stable while stallreq_o=1. The cache latches index/tag/hit at issue so it does not depend on this.
- Reset, when rst=0 at an edge:
  - state=IDLE; all valid bits cleared in that cycle.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_sel_o=0, mem_data_o=0, rdata_q=0.
  - While rst=0: stallreq_o=0 and cpu_data_o=0 combinationally.
- Reset mid-transaction: request is abandoned, mem_req_o low the next cycle. A late ack after reset is ignored.
- Sub-word reads return the full word. Byte extraction is the core's responsibility.
- Index wrap: addresses differing only in tag evict each other. A fill always overwrites.

Optional Feature:
MEM_CACHE_STAT_EN:
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - IDLE read hit with cpu_ce_i=1 increments hit_cnt_o.
  - Read miss entering FILL increments miss_cnt_o.
  - Writes are not counted.
  - Counters wrap at 2**32 and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset, then read 0x0000_0100 with memory word 0xDEADBEEF, ack 3 cycles after req. Expect stallreq_o=1 from issue through the ack cycle, mem_addr_o=0x100, mem_sel_o=4'hF, then DONE with cpu_data_o=0xDEADBEEF and stallreq_o=0. A re-read of 0x100 hits with zero stall and no mem_req_o.
2. Read 0x100 (filled), then read 0x0000_0200 (same index, INDEX_W=6) with memory 0x12345678. Expect a miss and fill. A following read of 0x100 misses again and issues mem_addr_o=0x100.
3. Write hit: 0x100 holds 0xDEADBEEF; write 0x000000AA, sel=4'b0001. Expect mem_we_o=1, mem_sel_o=4'b0001. After ack, read 0x100 hits and returns 0xDEADBEAA.
4. Write miss to 0x0000_0300. Expect write-through only. A following read of 0x300 misses and issues a fill (no allocate).
5. Assert rst=0 during FILL before ack, then pulse mem_ack_i one cycle later. Expect mem_req_o=0 after reset, state IDLE, no valid bit set. A subsequent read of the same address misses.
6. MEM_CACHE_STAT_EN defined, sequence miss, hit, hit, write. Expect miss_cnt_o=1, hit_cnt_o=2.
